// File: rtl/pcileech_tlp_fifo2axis_tx_if.sv
// pcileech_tlp_fifo2axis_tx_if: dword TLP input stream plus 64-bit AXI-Stream TX bundle
interface pcileech_tlp_fifo2axis_tx_if;
    logic [31:0] tx_data;
    logic        tx_last;
    logic        tx_valid;
    logic [63:0] axis_data;
    logic [7:0]  axis_keep;
    logic        axis_last;
    logic [21:0] axis_user;
    logic        axis_valid;
    logic        axis_ready;
    modport slave (
        input  tx_data, tx_last, tx_valid, axis_ready,
        output axis_data, axis_keep, axis_last, axis_user, axis_valid
    );
    modport master (
        output tx_data, tx_last, tx_valid, axis_ready,
        input  axis_data, axis_keep, axis_last, axis_user, axis_valid
    );
endinterface

// File: rtl/pcileech_tlp_fifo2axis_tx.sv
// pcileech_tlp_fifo2axis_tx: packs 32-bit TLP dwords into a store-and-forward qword buffer, emits whole TLPs on 64-bit AXI-Stream
module pcileech_tlp_fifo2axis_tx #(
    parameter int BUF_QW = 256,
    parameter int MAX_DW = 132
) (
    input  logic                               clk,
    input  logic                               rst_n,
    pcileech_tlp_fifo2axis_tx_if.slave         bus,
    output logic [15:0]                        drop_cnt,
    output logic [7:0]                         tlp_pending
);
    localparam int AW = $clog2(BUF_QW);
    localparam int CW = $clog2(MAX_DW + 1) + 1;
    localparam logic [AW:0]   FULL_LVL = (AW + 1)'(BUF_QW);
    localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_DW);

    logic [65:0]   mem [BUF_QW];
    logic [AW:0]   wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [31:0]   half_q, half_d;
    logic          half_vld_q, half_vld_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          drop_q, drop_d;
    logic [15:0]   drop_cnt_q, drop_cnt_d;
    logic [7:0]    pend_q, pend_d;
    logic [63:0]   data_q, data_d;
    logic [7:0]    keep_q, keep_d;
    logic          last_q, last_d, valid_q, valid_d;
    logic          wr_ev, over, full, drop_now, wr_en, eop, load, inc, dec;
    logic [65:0]   wr_word, rd_word;

    assign wr_ev    = bus.tx_valid & (half_vld_q | bus.tx_last);
    assign cnt_inc  = cnt_q + 1'b1;
    assign over     = cnt_inc > MAX_CNT;
    assign full     = (wr_ptr_q - rd_ptr_q) == FULL_LVL;
    assign drop_now = drop_q | (wr_ev & (full | over));
    assign wr_en    = wr_ev & ~drop_now;
    assign wr_word  = half_vld_q ? {bus.tx_last, 1'b1, bus.tx_data, half_q} : {1'b1, 1'b0, 32'h0, bus.tx_data};
    assign eop      = bus.tx_valid & bus.tx_last;
    assign inc      = eop & ~drop_now;
    assign dec      = valid_q & bus.axis_ready & last_q;
    assign load     = (rd_ptr_q != commit_ptr_q) & (~valid_q | bus.axis_ready);
    assign rd_word  = mem[rd_ptr_q[AW-1:0]];

    assign bus.axis_data  = data_q;
    assign bus.axis_keep  = keep_q;
    assign bus.axis_last  = last_q;
    assign bus.axis_user  = '0;
    assign bus.axis_valid = valid_q;
    assign drop_cnt       = drop_cnt_q;
    assign tlp_pending    = pend_q;

    // Next state: packing, commit/rollback of the write side, and output register reload
    always_comb begin
        wr_ptr_d     = eop & drop_now ? commit_ptr_q : wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        commit_ptr_d = inc ? wr_ptr_q + 1'b1 : commit_ptr_q;
        half_d       = bus.tx_valid & ~half_vld_q ? bus.tx_data : half_q;
        half_vld_d   = bus.tx_valid ? ~half_vld_q & ~bus.tx_last : half_vld_q;
        cnt_d        = ~bus.tx_valid ? cnt_q : bus.tx_last ? '0 : over ? cnt_q : cnt_inc;
        drop_d       = bus.tx_valid ? drop_now & ~bus.tx_last : drop_q;
        drop_cnt_d   = eop & drop_now & (drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 1'b1 : drop_cnt_q;
        pend_d       = inc & ~dec & (pend_q != 8'hFF) ? pend_q + 1'b1 :
                       dec & ~inc & (pend_q != 8'h00) ? pend_q - 1'b1 : pend_q;
        rd_ptr_d     = load ? rd_ptr_q + 1'b1 : rd_ptr_q;
        valid_d      = load | (valid_q & ~bus.axis_ready);
        data_d       = load ? rd_word[63:0] : data_q;
        keep_d       = load ? (rd_word[64] ? 8'hFF : 8'h0F) : keep_q;
        last_d       = load ? rd_word[65] : last_q;
    end

    // State registers; reset discards buffered and partially packed data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            half_q       <= '0;
            half_vld_q   <= 1'b0;
            cnt_q        <= '0;
            drop_q       <= 1'b0;
            drop_cnt_q   <= '0;
            pend_q       <= '0;
            data_q       <= '0;
            keep_q       <= '0;
            last_q       <= 1'b0;
            valid_q      <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            half_q       <= half_d;
            half_vld_q   <= half_vld_d;
            cnt_q        <= cnt_d;
            drop_q       <= drop_d;
            drop_cnt_q   <= drop_cnt_d;
            pend_q       <= pend_d;
            data_q       <= data_d;
            keep_q       <= keep_d;
            last_q       <= last_d;
            valid_q      <= valid_d;
        end
    end

    // Qword buffer write port: {last, keep_full, data}
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q[AW-1:0]] <= wr_word;
    end
endmodule

// File: tb/tb_pcileech_tlp_fifo2axis_tx.sv
// tb_pcileech_tlp_fifo2axis_tx: directed self-checking bench for the TLP dword-to-AXIS transmit packer
module tb_pcileech_tlp_fifo2axis_tx;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] tx_data = '0;
    logic        tx_last = 1'b0;
    logic        tx_valid = 1'b0;
    logic        rdy_a = 1'b1;
    logic        rdy_b = 1'b1;
    logic [15:0] drop_a, drop_b;
    logic [7:0]  pend_a, pend_b;
    int          checks = 0;
    int          errors = 0;
    logic [72:0] q_a[$];
    logic [72:0] q_b[$];
    logic [31:0] pkt[$];

    always #5 clk = ~clk;

    pcileech_tlp_fifo2axis_tx_if if_a ();
    pcileech_tlp_fifo2axis_tx_if if_b ();

    assign if_a.tx_data    = tx_data;
    assign if_a.tx_last    = tx_last;
    assign if_a.tx_valid   = tx_valid;
    assign if_a.axis_ready = rdy_a;
    assign if_b.tx_data    = tx_data;
    assign if_b.tx_last    = tx_last;
    assign if_b.tx_valid   = tx_valid;
    assign if_b.axis_ready = rdy_b;

    pcileech_tlp_fifo2axis_tx u_a (
        .clk(clk), .rst_n(rst_n), .bus(if_a), .drop_cnt(drop_a), .tlp_pending(pend_a)
    );

    pcileech_tlp_fifo2axis_tx #(.BUF_QW(8)) u_b (
        .clk(clk), .rst_n(rst_n), .bus(if_b), .drop_cnt(drop_b), .tlp_pending(pend_b)
    );

    // Collect every accepted beat as {last, keep, data}
    always @(negedge clk) begin
        if (rst_n && if_a.axis_valid && if_a.axis_ready) q_a.push_back({if_a.axis_last, if_a.axis_keep, if_a.axis_data});
        if (rst_n && if_b.axis_valid && if_b.axis_ready) q_b.push_back({if_b.axis_last, if_b.axis_keep, if_b.axis_data});
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send();
        for (int i = 0; i < pkt.size(); i++) begin
            tx_valid = 1'b1;
            tx_data  = pkt[i];
            tx_last  = (i == pkt.size() - 1);
            step();
        end
        tx_valid = 1'b0;
        tx_last  = 1'b0;
    endtask

    task automatic fill(input logic [31:0] base, input int n);
        pkt.delete();
        for (int i = 0; i < n; i++) pkt.push_back(base + 32'(i));
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        step(2);
        rst_n = 1'b1;
        step();
        q_a.delete();
        q_b.delete();
    endtask

    function automatic logic [72:0] exp_beat(input logic [31:0] base, input int j, input int nb);
        return {(j == nb - 1), 8'hFF, base + 32'(2 * j + 1), base + 32'(2 * j)};
    endfunction

    task automatic chk_beats(input string tag, input bit sel, input int off, input logic [31:0] base, input int nb);
        int bad = 0;
        for (int j = 0; j < nb; j++) begin
            logic [72:0] e;
            if (off + j >= (sel ? q_b.size() : q_a.size())) bad++;
            else begin
                e = sel ? q_b[off + j] : q_a[off + j];
                if (e !== exp_beat(base, j, nb)) bad++;
            end
        end
        chk(tag, 80'(bad), 80'd0);
    endtask

    initial begin
        logic [72:0] prev, cur;
        logic        pv, pr;
        int          stalls, gaps;
        bit          started;
        rst_n = 1'b0;
        step(2);
        chk("rst_valid", 80'(if_a.axis_valid), 80'd0);
        chk("rst_data", 80'(if_a.axis_data), 80'd0);
        chk("rst_keep", 80'(if_a.axis_keep), 80'd0);
        chk("rst_last", 80'(if_a.axis_last), 80'd0);
        chk("rst_user", 80'(if_a.axis_user), 80'd0);
        chk("rst_drop", 80'(drop_a), 80'd0);
        chk("rst_pend", 80'(pend_a), 80'd0);
        rst_n = 1'b1;
        step();

        pkt = '{32'h4A000001, 32'h01000004, 32'h12345678, 32'hDEADBEEF};
        send();
        chk("t4_lat_valid", 80'(if_a.axis_valid), 80'd0);
        chk("t4_pend1", 80'(pend_a), 80'd1);
        step();
        chk("t4_b0_valid", 80'(if_a.axis_valid), 80'd1);
        chk("t4_b0_data", 80'(if_a.axis_data), 80'h01000004_4A000001);
        chk("t4_b0_keep", 80'(if_a.axis_keep), 80'hFF);
        chk("t4_b0_last", 80'(if_a.axis_last), 80'd0);
        step();
        chk("t4_b1_data", 80'(if_a.axis_data), 80'hDEADBEEF_12345678);
        chk("t4_b1_keep", 80'(if_a.axis_keep), 80'hFF);
        chk("t4_b1_last", 80'(if_a.axis_last), 80'd1);
        chk("t4_b1_pend", 80'(pend_a), 80'd1);
        step();
        chk("t4_end_valid", 80'(if_a.axis_valid), 80'd0);
        chk("t4_end_pend", 80'(pend_a), 80'd0);

        q_a.delete();
        pkt = '{32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003};
        send();
        pkt = '{32'h11112222};
        send();
        step(6);
        chk("t3_count", 80'(q_a.size()), 80'd3);
        chk("t3_b0", 80'(q_a[0]), 80'({1'b0, 8'hFF, 32'hBBBB0002, 32'hAAAA0001}));
        chk("t3_b1", 80'(q_a[1]), 80'({1'b1, 8'h0F, 32'h00000000, 32'hCCCC0003}));
        chk("t1_b0", 80'(q_a[2]), 80'({1'b1, 8'h0F, 32'h00000000, 32'h11112222}));

        rdy_a = 1'b0;
        q_a.delete();
        fill(32'h10000000, 132);
        send();
        fill(32'h20000000, 4);
        send();
        chk("stall_pend2", 80'(pend_a), 80'd2);
        pv = 1'b0;
        pr = 1'b0;
        prev = '0;
        stalls = 0;
        gaps = 0;
        started = 1'b0;
        for (int c = 0; c < 400 && q_a.size() < 68; c++) begin
            cur = {if_a.axis_last, if_a.axis_keep, if_a.axis_data};
            if (pv && !pr && (!if_a.axis_valid || cur !== prev)) stalls++;
            if (if_a.axis_valid) started = 1'b1;
            else if (started) gaps++;
            rdy_a = (c % 4 == 0) || (c % 4 == 3);
            pv = if_a.axis_valid;
            pr = rdy_a;
            prev = cur;
            step();
        end
        rdy_a = 1'b1;
        step();
        chk("stall_hold", 80'(stalls), 80'd0);
        chk("stall_gaps", 80'(gaps), 80'd0);
        chk("stall_count", 80'(q_a.size()), 80'd68);
        chk_beats("stall_tlp66", 1'b0, 0, 32'h10000000, 66);
        chk_beats("stall_tlp2", 1'b0, 66, 32'h20000000, 2);
        chk("stall_pend0", 80'(pend_a), 80'd0);

        do_reset();
        rdy_a = 1'b1;
        rdy_b = 1'b0;
        fill(32'h30000000, 10);
        send();
        fill(32'h40000000, 20);
        send();
        chk("full_drop", 80'(drop_b), 80'd1);
        chk("full_pend", 80'(pend_b), 80'd1);
        chk("full_big_drop", 80'(drop_a), 80'd0);
        rdy_b = 1'b1;
        step(10);
        chk("full_count", 80'(q_b.size()), 80'd5);
        chk_beats("full_tlp10", 1'b1, 0, 32'h30000000, 5);
        chk("full_pend0", 80'(pend_b), 80'd0);

        do_reset();
        fill(32'h50000000, 134);
        send();
        fill(32'h5A000000, 4);
        send();
        step(6);
        chk("long_drop", 80'(drop_a), 80'd1);
        chk("long_count", 80'(q_a.size()), 80'd2);
        chk_beats("long_next", 1'b0, 0, 32'h5A000000, 2);
        chk("long_pend", 80'(pend_a), 80'd0);

        do_reset();
        rdy_a = 1'b0;
        fill(32'h70000000, 4);
        send();
        step();
        chk("mid_valid", 80'(if_a.axis_valid), 80'd1);
        chk("mid_pend", 80'(pend_a), 80'd1);
        fill(32'h71000000, 6);
        for (int i = 0; i < 3; i++) begin
            tx_valid = 1'b1;
            tx_data  = pkt[i];
            tx_last  = 1'b0;
            step();
        end
        rst_n = 1'b0;
        tx_valid = 1'b0;
        #1;
        chk("arst_valid", 80'(if_a.axis_valid), 80'd0);
        chk("arst_data", 80'(if_a.axis_data), 80'd0);
        chk("arst_keep", 80'(if_a.axis_keep), 80'd0);
        chk("arst_last", 80'(if_a.axis_last), 80'd0);
        chk("arst_pend", 80'(pend_a), 80'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q_a.delete();
        rdy_a = 1'b1;
        fill(32'h7E000000, 2);
        send();
        step(4);
        chk("post_count", 80'(q_a.size()), 80'd1);
        chk("post_beat", 80'(q_a[0]), 80'({1'b1, 8'hFF, 32'h7E000001, 32'h7E000000}));
        chk("post_pend", 80'(pend_a), 80'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pcileech_tlp_fifo2axis_tx.md
Name: pcileech_tlp_fifo2axis_tx

Overview:
- PCIe-side consumer of the FIFO-to-PCIe TLP transmit path.
- Accepts the 32-bit dword stream (tx_data/tx_last/tx_valid, no backpressure) from the FIFO/command decoder.
- Packs dwords into 64-bit qwords in a store-and-forward buffer.
- Emits only complete TLPs on the 64-bit AXI TX source toward the PCIe core, with no intra-TLP valid gaps.

Parameters:
BUF_QW, 256, buffer depth in qwords; power of 2, >= 2*MAX_DW/2.
MAX_DW, 132, max TLP length in dwords (4 hdr + 128 payload); longer TLPs are dropped.

Ports:
clk  in  1  PCIe user clock
rst_n  in  1  asynchronous active-low reset
tx_data  in  32  TLP dword, little-endian dword order (DW0 first)
tx_last  in  1  marks final dword of TLP
tx_valid  in  1  dword valid; no ready, accepted every cycle
axis_data  out  64  TX data; earlier dword in [31:0]
axis_keep  out  8  byte enables: 8'hFF, or 8'h0F on odd-length last beat
axis_last  out  1  final beat of TLP
axis_user  out  22  tied 22'h0
axis_valid  out  1  beat valid
axis_ready  in  1  sink ready
drop_cnt  out  16  saturating count of dropped TLPs
tlp_pending  out  8  committed TLPs not yet fully sent, saturating at 255

Behaviour:
- Reset (async assert, sync deassert by integrator):
  - All outputs 0; wr_ptr, commit_ptr, rd_ptr, pack state and drop flag cleared.
  - Reset mid-TLP discards all buffered and partial data.
- Pointers are log2(BUF_QW)+1 bits. used = wr_ptr - rd_ptr (mod wrap). full when used == BUF_QW.
- Packing:
  - A half register holds an even dword (DW0, DW2, ...).
  - On the odd dword, {dw_odd, dw_even} is written at that edge with keep FF, last=tx_last.
  - On tx_last with an even dword, {32'h0, dw} is written with keep 0F, last=1, and the half register clears.
  - A dword counter per TLP resets on tx_last.
- Commit: on the edge writing a last qword, commit_ptr <= new wr_ptr and tlp_pending++.
- Drop conditions, evaluated per qword write:
  - The write would find the buffer full.
  - The dword count exceeds MAX_DW.
  - On either condition, set the drop flag and suppress writes until tx_last.
  - On that tx_last: wr_ptr <= commit_ptr, no commit, drop_cnt++ (saturating at FFFF), clear flag.
  - Earlier complete TLPs are never affected.
- tx_valid with tx_last on the first dword of a TLP is a valid 1-DW TLP (keep 0F).
- Output stage:
  - A single output register is loaded from mem[rd_ptr] when rd_ptr != commit_ptr and (!axis_valid or axis_ready); rd_ptr++ on load.
  - axis_valid, data, keep and last hold stable while axis_valid && !axis_ready.
  - axis_valid drops only after the accepted last beat when no further committed qword exists.
- Latency: final dword sampled at edge k -> first beat valid after edge k+1.
- Throughput: 1 qword/cycle out versus 0.5 qword/cycle in, so back-to-back TLPs stream with axis_valid continuously high.
- tlp_pending decrements on an accepted beat with axis_last. Simultaneous increment and decrement leaves it unchanged.
- Simultaneous write, commit, load and wrap-around are legal in one cycle.
- Full is checked against rd_ptr after the load in that cycle is not credited (conservative).

Test Plan:
- 4-DW TLP 0x4A000001,0x01000004,0x12345678,0xDEADBEEF, ready=1 -> beats {0x01000004_4A000001, keep FF, last 0}, {0xDEADBEEF_12345678, keep FF, last 1}; valid after edge k+1; tlp_pending 1->0.
- 3-DW TLP A,B,C -> beats {B_A, FF}, {0_C, 0F, last}; 1-DW TLP X -> single beat {0_X, 0F, last}.
- axis_ready toggling 1,0,0,1 during a 66-beat TLP -> data stable while stalled, no beat lost or duplicated; two queued TLPs sent back-to-back without valid gap.
- BUF_QW=8, ready=0, send a 10-DW then 20-DW TLP -> 10-DW kept (5 qwords); 20-DW dropped; drop_cnt=1; after ready=1 only the 10-DW TLP emerges.
- 134-DW TLP followed by a 4-DW TLP -> drop_cnt=1; only the 4-DW TLP appears.
- rst_n low for 1 cycle mid-TLP and mid-output -> all outputs 0 immediately; the next TLP after release is emitted correctly.
